// File: rtl/muldiv_pkg.sv
// muldiv_pkg -- shared definitions for the HI/LO multiply/divide controller.
//   * 4-bit operation codes driven on muldiv_ctrl.op
//   * FSM state encoding (IDLE / RUN)
//   * busy-counter width
//   * helpers that classify an op code as legal / multi-cycle
// Optional feature macro: MULDIV_MADD_EN enables OP_MADD/OP_MADDU/OP_MSUB/OP_MSUBU.
// Without it those codes behave exactly like OP_NONE.
package muldiv_pkg;

  localparam int CNT_W = 4;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Ops that go through the pending register and hold busy.
  function automatic logic op_is_long(input logic [3:0] op);
    logic r;
    r = 1'b0;
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: r = 1'b1;
`ifdef MULDIV_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Ops that may be accepted at all; everything else is treated as OP_NONE.
  function automatic logic op_is_legal(input logic [3:0] op);
    return op_is_long(op) || (op == OP_MTHI) || (op == OP_MTLO);
  endfunction

  // Divides use the longer latency; every other long op uses the multiply latency.
  function automatic logic op_is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_calc.sv
// muldiv_calc -- purely combinational result generator for the md unit.
// Produces the 64-bit {hi,lo} value an accepted op will eventually write:
//   mult/multu  : 64-bit product
//   div/divu    : {remainder, quotient}, with divide-by-zero and the signed
//                 overflow case (0x80000000 / -1) forced to fixed values
//   mthi/mtlo   : current {hi,lo} with the addressed half replaced by rs_val
//   madd family : {hi,lo} +/- product (only with MULDIV_MADD_EN)
//   other codes : current {hi,lo} unchanged
// Ports:
//   op      in  [3:0]  operation code (muldiv_pkg)
//   rs_val  in  [31:0] rs operand
//   rt_val  in  [31:0] rt operand
//   hi, lo  in  [31:0] current HI/LO
//   result  out [63:0] {new_hi, new_lo}
module muldiv_calc
  import muldiv_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] result
);

  logic signed [63:0] rs_sext;
  logic signed [63:0] rt_sext;
  logic        [63:0] prod_s;
  logic        [63:0] prod_u;
  logic               div_zero;
  logic               div_ovf;
  logic signed [31:0] dividend_s;
  logic signed [31:0] divisor_s;
  logic        [31:0] divisor_u;
  logic        [31:0] quot_s;
  logic        [31:0] rem_s;
  logic        [31:0] quot_u;
  logic        [31:0] rem_u;
  logic        [63:0] acc;

  always_comb begin
    rs_sext  = {{32{rs_val[31]}}, rs_val};
    rt_sext  = {{32{rt_val[31]}}, rt_val};
    prod_s   = rs_sext * rt_sext;
    prod_u   = {32'd0, rs_val} * {32'd0, rt_val};
    acc      = {hi, lo};

    div_zero = (rt_val == 32'd0);
    div_ovf  = (rs_val == 32'h8000_0000) && (rt_val == 32'hFFFF_FFFF);

    // The divider never sees a zero divisor or the overflowing pair; those
    // results are substituted below, so a safe divisor of 1 is used instead.
    dividend_s = rs_val;
    divisor_s  = (div_zero || div_ovf) ? 32'sd1 : rt_val;
    divisor_u  = div_zero ? 32'd1 : rt_val;
    quot_s     = dividend_s / divisor_s;   // truncates toward zero
    rem_s      = dividend_s % divisor_s;   // sign follows the dividend
    quot_u     = rs_val / divisor_u;
    rem_u      = rs_val % divisor_u;

    result = acc;
    case (op)
      OP_MULT:  result = prod_s;
      OP_MULTU: result = prod_u;
      OP_DIV: begin
        if (div_zero)     result = {rs_val, 32'hFFFF_FFFF};
        else if (div_ovf) result = {32'd0, 32'h8000_0000};
        else              result = {rem_s, quot_s};
      end
      OP_DIVU: begin
        if (div_zero) result = {rs_val, 32'hFFFF_FFFF};
        else          result = {rem_u, quot_u};
      end
      OP_MTHI:  result = {rs_val, lo};
      OP_MTLO:  result = {hi, rs_val};
`ifdef MULDIV_MADD_EN
      OP_MADD:  result = acc + prod_s;
      OP_MADDU: result = acc + prod_u;
      OP_MSUB:  result = acc - prod_s;
      OP_MSUBU: result = acc - prod_u;
`endif
      default:  result = acc;
    endcase
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl -- sequencing controller for the HI/LO multiply/divide resource.
// An accepted md op has its result computed at issue, parked in a pending
// register, and committed to HI/LO after a fixed latency while busy is held.
// mthi/mtlo write HI/LO directly at the accept edge.
// Optional feature macro: MULDIV_MADD_EN (madd/maddu/msub/msubu).
// Parameters:
//   MULT_CYCLES  busy cycles for mult/multu/madd family (1..15)
//   DIV_CYCLES   busy cycles for div/divu (1..15)
// Ports:
//   clk     in        rising-edge clock
//   reset   in        asynchronous active-low reset
//   start   in        issue strobe from E stage
//   op      in  [3:0] operation code (muldiv_pkg)
//   rs_val  in  [31:0] rs operand
//   rt_val  in  [31:0] rt operand
//   flush   in        cancels a start in the same cycle
//   busy    out       md operation in flight
//   hi, lo  out [31:0] HI / LO registers
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [31:0]      ph_reg, ph_next;
  logic [31:0]      pl_reg, pl_next;
  logic [31:0]      hi_reg, hi_next;
  logic [31:0]      lo_reg, lo_next;
  logic [63:0]      calc_result;
  logic             accept;

  muldiv_calc u_calc (
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .hi     (hi_reg),
    .lo     (lo_reg),
    .result (calc_result)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      count_reg <= '0;
      ph_reg    <= '0;
      pl_reg    <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      ph_reg    <= ph_next;
      pl_reg    <= pl_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
    end
  end

  // Next-state logic. Only IDLE can accept, so a start while busy is dropped
  // and a flush arriving during RUN has no effect on the op in flight.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    ph_next    = ph_reg;
    pl_next    = pl_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    accept     = start && !flush && (state_reg == IDLE) && op_is_legal(op);

    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (op_is_long(op)) begin
            state_next         = RUN;
            count_next         = op_is_div(op) ? DIV_N : MULT_N;
            {ph_next, pl_next} = calc_result;
          end else begin
            {hi_next, lo_next} = calc_result;
          end
        end
      end
      RUN: begin
        // Counter was loaded with N, so the commit edge is the N-th after accept.
        if (count_reg == CNT_W'(1)) begin
          state_next = IDLE;
          count_next = '0;
          hi_next    = ph_reg;
          lo_next    = pl_reg;
        end else begin
          count_next = count_reg - CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    busy = (state_reg == RUN);
    hi   = hi_reg;
    lo   = lo_reg;
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        flush = 1'b0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;
  int n;

  muldiv_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .flush  (flush),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction: drive for one edge, then return the bus to idle.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic fl);
    start = 1'b1; op = o; rs_val = a; rt_val = b; flush = fl;
    tick();
    $display("txn op=%0d rs=%h rt=%h flush=%0b -> busy=%0b hi=%h lo=%h",
             o, a, b, fl, busy, hi, lo);
    start = 1'b0; op = OP_NONE; flush = 1'b0;
  endtask

  // Counts sampled cycles with busy high, bounded so a stuck busy cannot hang.
  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    reset = 1'b1;
    tick();

    // mult -2 * 3
    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
    check("mult_lo_hold", lo, 32'd0);
    wait_idle(n);
    check("mult_latency", n, 32'd5);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);

    // multu 0xFFFFFFFE * 3
    issue(OP_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0);
    wait_idle(n);
    check("multu_latency", n, 32'd5);
    check("multu_hi", hi, 32'd2);
    check("multu_lo", lo, 32'hFFFF_FFFA);

    // div -7 / 2
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_idle(n);
    check("div_latency", n, 32'd10);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    // div 7 / -2 -> q=-3, r=1
    issue(OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0);
    wait_idle(n);
    check("div_neg_lo", lo, 32'hFFFF_FFFD);
    check("div_neg_hi", hi, 32'd1);

    // divu 7 / 0
    issue(OP_DIVU, 32'd7, 32'd0, 1'b0);
    wait_idle(n);
    check("divu0_lo", lo, 32'hFFFF_FFFF);
    check("divu0_hi", hi, 32'd7);

    // div -5 / 0
    issue(OP_DIV, 32'hFFFF_FFFB, 32'd0, 1'b0);
    wait_idle(n);
    check("div0_lo", lo, 32'hFFFF_FFFF);
    check("div0_hi", hi, 32'hFFFF_FFFB);

    // div 0x80000000 / -1
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_idle(n);
    check("divovf_lo", lo, 32'h8000_0000);
    check("divovf_hi", hi, 32'd0);

    // start+flush on mthi is dropped; plain mthi writes at once
    issue(OP_MTHI, 32'd5, 32'd0, 1'b1);
    check("flush_mthi_hi", hi, 32'd0);
    check("flush_mthi_busy", {31'd0, busy}, 32'd0);
    issue(OP_MTHI, 32'd5, 32'd0, 1'b0);
    check("mthi_hi", hi, 32'd5);
    check("mthi_busy", {31'd0, busy}, 32'd0);

    // unknown op code is never accepted
    issue(4'd15, 32'd1, 32'd1, 1'b0);
    check("op15_busy", {31'd0, busy}, 32'd0);
    check("op15_hi", hi, 32'd5);

    // start during busy is ignored, original op commits on schedule
    issue(OP_MULT, 32'd6, 32'd7, 1'b0);
    issue(OP_MTLO, 32'h1234, 32'd0, 1'b0);
    check("busy_mtlo_lo", lo, 32'h8000_0000);
    wait_idle(n);
    check("busy_mtlo_rest", n, 32'd4);
    check("busy_mult_hi", hi, 32'd0);
    check("busy_mult_lo", lo, 32'd42);

    // flush during RUN does not cancel: divu 100 / 7
    issue(OP_DIVU, 32'd100, 32'd7, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_idle(n);
    check("runflush_rest", n, 32'd9);
    check("runflush_lo", lo, 32'd14);
    check("runflush_hi", hi, 32'd2);

    // back-to-back
    issue(OP_MTLO, 32'd9, 32'd0, 1'b0);
    check("b2b_mtlo_lo", lo, 32'd9);
    issue(OP_DIVU, 32'd20, 32'd6, 1'b0);
    wait_idle(n);
    check("b2b_divu_lo", lo, 32'd3);
    check("b2b_divu_hi", hi, 32'd2);
    issue(OP_MULTU, 32'd3, 32'd4, 1'b0);
    check("b2b_accept", {31'd0, busy}, 32'd1);
    wait_idle(n);
    check("b2b_latency", n, 32'd5);
    check("b2b_hi", hi, 32'd0);
    check("b2b_lo", lo, 32'd12);

    // reset in cycle 4 of a divide
    issue(OP_DIV, 32'd100, 32'd3, 1'b0);
    tick(); tick(); tick();
    reset = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    tick(); tick();
    reset = 1'b1;
    n = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (busy !== 1'b0) n++;
    end
    check("midrst_nobusy", n, 32'd0);
    check("midrst_hi_after", hi, 32'd0);
    check("midrst_lo_after", lo, 32'd0);

    // madd family
    issue(OP_MTHI, 32'd0, 32'd0, 1'b0);
    issue(OP_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0);
    issue(OP_MADDU, 32'd1, 32'd1, 1'b0);
`ifdef MULDIV_MADD_EN
    wait_idle(n);
    check("maddu_latency", n, 32'd5);
    check("maddu_hi", hi, 32'd1);
    check("maddu_lo", lo, 32'd0);
`else
    check("maddu_off_busy", {31'd0, busy}, 32'd0);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (busy !== 1'b0) n++;
    end
    check("maddu_off_nobusy", n, 32'd0);
    check("maddu_off_hi", hi, 32'd0);
    check("maddu_off_lo", lo, 32'hFFFF_FFFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Sequencing controller for the HI/LO multiply/divide resource in the E stage of the 5-stage MIPS pipeline.
- Accepts one md operation per start pulse and computes the result at issue.
- Holds `busy` for a fixed per-op latency, then commits to HI/LO.
- Sources the `start`/`busy` pair the pipeline hazard unit uses to stall mfhi/mflo/md instructions in D.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd family); legal range 1..15
- DIV_CYCLES, 10, busy cycles for div/divu; legal range 1..15

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous active-low reset; 0 clears all state immediately
- start  input  1  issue strobe from E stage, one cycle per instruction
- op  input  4  operation code, encoding in shared package
- rs_val  input  32  forwarded rs operand (dividend / multiplicand / mthi-mtlo data)
- rt_val  input  32  forwarded rt operand
- flush  input  1  exception/interrupt cancel from M stage; suppresses start in the same cycle
- busy  output  1  md operation in flight
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset: busy=0, hi=0, lo=0, counter=0, pending result=0. A reset during an operation aborts it with no commit.
- Accept condition: start && !flush && !busy && op!=OP_NONE. An accepted start is registered at the rising edge.
  - start while busy=1: ignored, no state change (the hazard unit guarantees this never happens; the bench asserts it).
  - start with flush=1: ignored entirely, including mthi/mtlo.
- mthi/mtlo: on acceptance, write rs_val into hi/lo at that edge. No busy, latency 0.
- mult/multu/div/divu:
  - At the accept edge: latch the 64-bit result into pending {ph,pl}, load counter with N (MULT_CYCLES or DIV_CYCLES), set busy=1.
  - State machine: IDLE -> RUN on accept. In RUN the counter decrements each cycle.
  - When counter==1, the next edge commits hi<=ph, lo<=pl, clears busy, and returns to IDLE.
  - busy is high for exactly N cycles. New hi/lo are visible in the first cycle busy=0.
  - A start in that cycle is accepted normally.
- flush during RUN does not cancel the operation: the instruction already passed E before the exception.
- Arithmetic:
  - mult: signed 32x32 to 64. multu: unsigned. {hi,lo} = product.
  - div: signed, quotient truncates toward zero, remainder takes the dividend's sign; lo=quotient, hi=remainder.
  - divu: unsigned.
  - Divisor 0 (div or divu): lo=32'hFFFFFFFF, hi=rs_val.
  - div 32'h80000000 / 32'hFFFFFFFF: lo=32'h80000000, hi=0.
- hi/lo change only on reset, mthi/mtlo, or commit.

Optional Feature:
- Macro MULDIV_MADD_EN.
- Defined: op codes OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU are legal. They use MULT_CYCLES latency.
  - The pending result is computed at the accept edge as {hi,lo} ± product, using the hi/lo values at accept time.
  - Signed ops use signed product; U variants use unsigned. 64-bit wrap, no saturation.
- Undefined: these codes are treated as OP_NONE. They are never accepted, busy stays 0, and hi/lo are unchanged.

Decomposition:
- Shared package muldiv_pkg:
  - 4-bit op localparams: OP_NONE=0, OP_MULT=1, OP_MULTU=2, OP_DIV=3, OP_DIVU=4, OP_MTHI=5, OP_MTLO=6, OP_MADD=7, OP_MADDU=8, OP_MSUB=9, OP_MSUBU=10.
  - State encoding IDLE/RUN.
  - 4-bit counter width.
- One sub-module, muldiv_calc: purely combinational 64-bit result from op, rs_val, rt_val, hi, lo, including the div-by-zero and overflow rules.
- muldiv_ctrl owns the FSM, counter, pending registers and HI/LO.

Test Plan:
- Reset: drive reset=0 mid-div (cycle 4 of 10) -> busy=0, hi=lo=0 immediately. After release, no commit ever occurs.
- mult latency: start, op=MULT, rs=32'hFFFFFFFE (-2), rt=3 -> busy high exactly 5 cycles, then hi=32'hFFFFFFFF, lo=32'hFFFFFFFA. Repeat with MULTU -> hi=2, lo=32'hFFFFFFFA.
- div signs and boundaries:
  - DIV rs=-7, rt=2 -> after 10 busy cycles lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
  - DIVU rs=7, rt=0 -> lo=32'hFFFFFFFF, hi=7.
  - DIV 32'h80000000 / -1 -> lo=32'h80000000, hi=0.
- Cancel and ignore:
  - start+flush with op=MTHI, rs=5 -> hi unchanged, busy=0.
  - start during busy with op=MTLO -> lo unchanged. The original op still commits on schedule.
- Back-to-back: MTLO rs=9 at cycle 0 -> lo=9 at cycle 1. MULTU 3x4 issued the first cycle busy=0 after a prior DIVU -> accepted. busy stays 0 for exactly one cycle between operations; final hi=0, lo=12.
- MULDIV_MADD_EN:
  - hi=0, lo=32'hFFFFFFFF, then MADDU rs=1, rt=1 -> hi=1, lo=0 after 5 cycles.
  - Without the macro, the same op -> busy never asserts, hi/lo unchanged.
